// File: rtl/mem_responder.sv
// Memory-side responder: 512x16 RAM plus LED/switch registers on the CPU mem bus, with a handshaked program loader.
// Latency: MREAD data registered one cycle after the command edge; MWRITE takes effect at the command edge.
// Backpressure: loader sees ld_ready only while in LOAD; the CPU bus is ignored whenever the loader is not IDLE.
module mem_responder #(
    parameter int             AW       = 9,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  LED_ADDR = 9'h100,
    parameter logic [AW-1:0]  SW_ADDR  = 9'h140
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    mem_cmd,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] write_data,
    output logic [DW-1:0] read_data,
    input  logic [7:0]    sw,
    output logic [7:0]    led,
    output logic          cmd_err,
    input  logic          ld_en,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic [AW:0]   ld_count
);

    localparam logic [2:0] CMD_NONE  = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam int         DEPTH     = 1 << AW;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_FULL = 2'd2
    } ld_state_t;

    ld_state_t     r_state;
    ld_state_t     w_state_nxt;
    logic          w_ld_start;
    logic          w_ld_accept;

    logic [AW-1:0] r_ld_ptr;
    logic [AW:0]   r_ld_count;
    logic          r_ld_ready;

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_read_data;
    logic [7:0]    r_led;
    logic          r_cmd_err;
    logic [7:0]    r_sw_meta;
    logic [7:0]    r_sw_sync;

    logic          w_cpu_act;
    logic          w_is_read;
    logic          w_is_write;
    logic          w_is_illegal;
    logic          w_led_hit;
    logic          w_sw_hit;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;

    // Loader state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loader next state; dropping ld_en wins over a word offered in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_start  = 1'b0;
        w_ld_accept = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (ld_en) begin
                    w_state_nxt = LD_LOAD;
                    w_ld_start  = 1'b1;
                end
            end
            LD_LOAD: begin
                if (!ld_en) begin
                    w_state_nxt = LD_IDLE;
                end else if (ld_valid) begin
                    w_ld_accept = 1'b1;
                    if (r_ld_ptr == {AW{1'b1}}) begin
                        w_state_nxt = LD_FULL;
                    end
                end
            end
            LD_FULL: begin
                if (!ld_en) begin
                    w_state_nxt = LD_IDLE;
                end
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    // Loader pointer/count and registered ready; pointer saturates at the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_ptr   <= '0;
            r_ld_count <= '0;
            r_ld_ready <= 1'b0;
        end else begin
            r_ld_ready <= (w_state_nxt == LD_LOAD);
            if (w_ld_start) begin
                r_ld_ptr   <= '0;
                r_ld_count <= '0;
            end else if (w_ld_accept) begin
                r_ld_count <= r_ld_count + 1'b1;
                if (r_ld_ptr != {AW{1'b1}}) begin
                    r_ld_ptr <= r_ld_ptr + 1'b1;
                end
            end
        end
    end

    // CPU command decode; the CPU owns the bus only while the loader is idle.
    always_comb begin
        w_cpu_act    = (r_state == LD_IDLE);
        w_is_read    = w_cpu_act && (mem_cmd == CMD_READ);
        w_is_write   = w_cpu_act && (mem_cmd == CMD_WRITE);
        w_is_illegal = w_cpu_act && (mem_cmd != CMD_READ) && (mem_cmd != CMD_WRITE)
                       && (mem_cmd != CMD_NONE);
        w_led_hit    = (mem_addr == LED_ADDR);
        w_sw_hit     = (mem_addr == SW_ADDR);
    end

    // Single RAM write port shared by loader and CPU stores to non-register addresses.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = mem_addr;
        w_mem_wdata = write_data;
        if (w_ld_accept) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_ld_ptr;
            w_mem_wdata = ld_data;
        end else if (w_is_write && !w_led_hit && !w_sw_hit) begin
            w_mem_we = 1'b1;
        end
    end

    // RAM array, deliberately not reset so loaded programs survive a reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Registered read data; holds on anything other than a legal MREAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else if (w_is_read) begin
            if (w_sw_hit) begin
                r_read_data <= {{(DW-8){1'b0}}, r_sw_sync};
            end else if (w_led_hit) begin
                r_read_data <= {{(DW-8){1'b0}}, r_led};
            end else begin
                r_read_data <= r_mem[mem_addr];
            end
        end
    end

    // LED register and sticky illegal-command flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            if (w_is_write && w_led_hit) begin
                r_led <= write_data[7:0];
            end
            if (w_is_illegal) begin
                r_cmd_err <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign read_data = r_read_data;
    assign led       = r_led;
    assign cmd_err   = r_cmd_err;
    assign ld_ready  = r_ld_ready;
    assign ld_count  = r_ld_count;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed loader/CPU steps plus a randomized CPU phase.
// Expected values come from a behavioural model (array RAM, LED/err flags, switch delay line).
// Inputs change after the falling edge; outputs are sampled at the falling edge after each rising edge.
module tb_mem_responder;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;
    localparam logic [8:0] LED_A  = 9'h100;
    localparam logic [8:0] SW_A   = 9'h140;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        cmd_err;
    logic        ld_en;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [9:0]  ld_count;

    // reference model state
    logic [15:0] m_mem [512];
    logic [7:0]  m_led;
    logic        m_err;
    logic [15:0] m_rd;
    logic [7:0]  m_s1;
    logic [7:0]  m_s2;

    int n_cmp;
    int n_err;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .sw         (sw),
        .led        (led),
        .cmd_err    (cmd_err),
        .ld_en      (ld_en),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the switch model sees the value present at the rising edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_s1 = 8'h00;
            m_s2 = 8'h00;
        end else begin
            m_s2 = m_s1;
            m_s1 = sw;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ld_en    = 1'b0;
        ld_valid = 1'b0;
        mem_cmd  = MNONE;
        tick();
        tick();
        reset = 1'b0;
        m_led = 8'h00;
        m_err = 1'b0;
        m_rd  = 16'h0000;
    endtask

    // CPU access with the loader idle; checks read_data, led and cmd_err afterwards.
    task automatic cpu_op(input string tag, input logic [2:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        if (cmd == MREAD) begin
            if (addr == SW_A)       m_rd = {8'h00, m_s2};
            else if (addr == LED_A) m_rd = {8'h00, m_led};
            else                    m_rd = m_mem[addr];
        end else if (cmd == MWRITE) begin
            if (addr == LED_A)      m_led = data[7:0];
            else if (addr != SW_A)  m_mem[addr] = data;
        end else if (cmd != MNONE) begin
            m_err = 1'b1;
        end
        tick();
        mem_cmd = MNONE;
        chk({tag, "_rd"},  32'(read_data), 32'(m_rd));
        chk({tag, "_led"}, 32'(led),       32'(m_led));
        chk({tag, "_err"}, 32'(cmd_err),   32'(m_err));
    endtask

    task automatic ld_step(input logic v, input logic [15:0] d);
        ld_valid = v;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [15:0] w;
        n_cmp = 0;
        n_err = 0;
        m_s1 = 8'h00;
        m_s2 = 8'h00;
        sw = 8'h00;
        ld_en = 1'b0;
        ld_valid = 1'b0;
        ld_data = 16'h0000;
        mem_cmd = MNONE;
        mem_addr = 9'h000;
        write_data = 16'h0000;
        reset = 1'b1;
        do_reset();

        chk("rst_rd",    32'(read_data), 32'h0);
        chk("rst_led",   32'(led),       32'h0);
        chk("rst_err",   32'(cmd_err),   32'h0);
        chk("rst_rdy",   32'(ld_ready),  32'h0);
        chk("rst_count", 32'(ld_count),  32'h0);

        // full 512-word load, word 5 = A5A5
        ld_en = 1'b1;
        tick();
        chk("full_entry_rdy",   32'(ld_ready), 32'h1);
        chk("full_entry_count", 32'(ld_count), 32'h0);
        for (int i = 0; i < 512; i++) begin
            rnd = $urandom;
            w = (i == 5) ? 16'hA5A5 : rnd[15:0];
            m_mem[i] = w;
            ld_step(1'b1, w);
            chk("full_count", 32'(ld_count), 32'(i + 1));
            if (i < 511) chk("full_rdy", 32'(ld_ready), 32'h1);
        end
        chk("full_rdy_low", 32'(ld_ready), 32'h0);
        ld_step(1'b1, 16'hDEAD);
        chk("full_513_count", 32'(ld_count), 32'd512);
        chk("full_513_rdy",   32'(ld_ready), 32'h0);
        ld_en = 1'b0;
        tick();
        chk("full_exit_count", 32'(ld_count), 32'd512);
        chk("full_exit_rdy",   32'(ld_ready), 32'h0);

        // reset keeps RAM; preloaded word readable with 1-cycle latency
        do_reset();
        chk("rst2_rd", 32'(read_data), 32'h0);
        cpu_op("read5", MREAD, 9'h005, 16'h0);
        chk("read5_val", 32'(read_data), 32'h0000A5A5);
        cpu_op("read0_no513", MREAD, 9'h000, 16'h0);

        // write then read, then idle hold
        cpu_op("wr10", MWRITE, 9'h010, 16'h1234);
        cpu_op("rd10", MREAD, 9'h010, 16'h0);
        chk("rd10_val", 32'(read_data), 32'h00001234);
        for (int i = 0; i < 3; i++) cpu_op("none_hold", MNONE, 9'h010, 16'hFFFF);

        // LED register
        cpu_op("wr_led", MWRITE, LED_A, 16'hFF3C);
        chk("led_val", 32'(led), 32'h3C);
        chk("led_ram_untouched", 32'(dut.r_mem[9'h100]), 32'(m_mem[256]));
        cpu_op("rd_led", MREAD, LED_A, 16'h0);

        // switches: 3 edges from change to read_data
        sw = 8'h5A;
        for (int i = 0; i < 3; i++) cpu_op("sw_settle", MNONE, 9'h0, 16'h0);
        cpu_op("rd_sw", MREAD, SW_A, 16'h0);
        chk("rd_sw_val", 32'(read_data), 32'h005A);
        cpu_op("wr_sw_ignored", MWRITE, SW_A, 16'h1111);
        sw = 8'hC3;
        cpu_op("sw_lat1", MREAD, SW_A, 16'h0);
        cpu_op("sw_lat2", MREAD, SW_A, 16'h0);
        cpu_op("sw_lat3", MREAD, SW_A, 16'h0);
        chk("sw_lat3_val", 32'(read_data), 32'h00C3);

        // randomized CPU traffic
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  c;
            logic [8:0]  a;
            int          r;
            int          r2;
            r   = $urandom_range(0, 99);
            r2  = $urandom_range(0, 9);
            rnd = $urandom;
            c = (r < 45) ? MREAD : ((r < 85) ? MWRITE : MNONE);
            if (r2 < 2)      a = LED_A;
            else if (r2 < 4) a = SW_A;
            else if (r2 < 7) a = {4'b0000, rnd[4:0]};
            else             a = rnd[24:16];
            if ($urandom_range(0, 4) == 0) begin
                rnd = $urandom;
                sw = rnd[7:0];
            end
            rnd = $urandom;
            cpu_op("rand", c, a, rnd[15:0]);
        end

        // illegal commands
        cpu_op("ill_110", 3'b110, 9'h020, 16'hBEEF);
        cpu_op("ill_rd20", MREAD, 9'h020, 16'h0);
        cpu_op("ill_000", 3'b000, 9'h021, 16'hBEEF);
        cpu_op("ill_wr", MWRITE, 9'h022, 16'h4242);
        cpu_op("ill_rd22", MREAD, 9'h022, 16'h0);
        chk("ill_sticky", 32'(cmd_err), 32'h1);
        do_reset();
        chk("ill_reset", 32'(cmd_err), 32'h0);

        // short load with a gap; CPU traffic during LOAD is ignored
        cpu_op("pre_ld_rd", MREAD, 9'h010, 16'h0);
        ld_en = 1'b1;
        tick();
        chk("sl_entry_rdy",   32'(ld_ready), 32'h1);
        chk("sl_entry_count", 32'(ld_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom;
            if (i == 2) begin
                mem_cmd  = MREAD;
                mem_addr = 9'h005;
                ld_step(1'b0, 16'hAAAA);
                chk("sl_gap_count", 32'(ld_count), 32'd2);
                chk("sl_gap_rd",    32'(read_data), 32'(m_rd));
                mem_cmd    = MWRITE;
                mem_addr   = LED_A;
                write_data = 16'h00FF;
            end
            if (i == 3) mem_cmd = 3'b111;
            m_mem[i] = rnd[15:0];
            ld_step(1'b1, rnd[15:0]);
            mem_cmd = MNONE;
            chk("sl_count", 32'(ld_count), 32'(i + 1));
            chk("sl_rd_hold", 32'(read_data), 32'(m_rd));
            chk("sl_led_hold", 32'(led), 32'(m_led));
            chk("sl_no_err", 32'(cmd_err), 32'h0);
        end
        ld_en = 1'b0;
        ld_step(1'b1, 16'h7777);
        chk("sl_exit_rdy",   32'(ld_ready), 32'h0);
        chk("sl_exit_count", 32'(ld_count), 32'd4);
        for (int i = 0; i < 5; i++) cpu_op("sl_rd", MREAD, 9'(i), 16'h0);
        chk("sl_count_hold", 32'(ld_count), 32'd4);

        // reset mid-load
        ld_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            rnd = $urandom;
            m_mem[i] = rnd[15:0];
            ld_step(1'b1, rnd[15:0]);
        end
        chk("ml_count10", 32'(ld_count), 32'd10);
        do_reset();
        chk("ml_count_rst", 32'(ld_count), 32'h0);
        chk("ml_rdy_rst",   32'(ld_ready), 32'h0);
        chk("ml_rd_rst",    32'(read_data), 32'h0);
        for (int i = 0; i < 11; i++) cpu_op("ml_rd", MREAD, 9'(i), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's `mem_cmd`/`mem_addr` bus. It contains a 512×16 data/instruction RAM and memory-mapped LED and switch registers. It answers every MREAD with registered data one cycle later, and performs MWRITEs at the clock edge. A handshaked program loader fills RAM while the CPU is held off the bus.

## Interface
Parameters:
- AW, 9: address width.
- DW, 16: data width.
- LED_ADDR, 9'h100: write/read address of the LED register.
- SW_ADDR, 9'h140: read-only address of the switch register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_cmd  in  3  one-hot command: 3'b001 MNONE, 3'b010 MREAD, 3'b100 MWRITE.
- mem_addr  in  AW  access address.
- write_data  in  DW  store data (CPU datapath output).
- read_data  out  DW  registered read data (to CPU `in`).
- sw  in  8  asynchronous switch inputs.
- led  out  8  LED register.
- cmd_err  out  1  sticky illegal-command flag.
- ld_en  in  1  loader enable; CPU bus ignored while loader active.
- ld_valid  in  1  loader word valid.
- ld_data  in  DW  loader word.
- ld_ready  out  1  loader can accept a word this cycle.
- ld_count  out  10  words loaded in current or last load session, 0..512.

## Operation
- Loader FSM has three states: IDLE, LOAD and FULL.
  - IDLE→LOAD when ld_en=1. ld_ptr and ld_count clear on entry.
  - In LOAD, ld_ready=1. On ld_valid&ld_ready&ld_en: mem[ld_ptr]<=ld_data, ld_ptr++, ld_count++.
  - Write of address 511 moves LOAD→FULL; ld_ready=0 in FULL. ld_ptr does not wrap.
  - LOAD or FULL→IDLE when ld_en=0. A ld_valid in that same cycle is dropped.
  - ld_count holds after return to IDLE until the next LOAD entry or reset.
- CPU port is active only in IDLE. In LOAD/FULL all mem_cmd values are ignored: no access, read_data holds, no cmd_err.
- MREAD at edge t: read_data is valid after edge t+1. Source depends on mem_addr:
  - mem_addr==SW_ADDR → {8'b0, sw_sync}.
  - mem_addr==LED_ADDR → {8'b0, led}.
  - Otherwise → mem[mem_addr].
- MWRITE at edge t:
  - mem_addr==LED_ADDR → led<=write_data[7:0]; RAM untouched.
  - mem_addr==SW_ADDR → ignored.
  - Otherwise → mem[mem_addr]<=write_data.
  - read_data holds.
- MNONE: no access; read_data holds its last value.
- Any other mem_cmd (3'b000, multi-hot): no access; read_data holds; cmd_err<=1 and stays 1 until reset.
- sw passes through a 2-flop synchronizer (sw_sync) before use.
- Reset values: read_data=0, led=0, cmd_err=0, sw_sync=0, loader IDLE, ld_ptr=0, ld_count=0, ld_ready=0. RAM contents are NOT cleared.
- Reset during LOAD aborts to IDLE with ld_count=0. Words already written stay in RAM.

## Timing
- Read latency is exactly 1 cycle. This suits the CPU's two-cycle fetch: address in Sif1, IR load in Sif2.
- Back-to-back MREADs yield one new word per cycle.
- Write then read of the same address: MWRITE at t, MREAD at t+1 returns the new data after edge t+2. No bypass is needed.
- Switch change reaches read_data no earlier than 3 edges after sw changes: 2 synchronizer edges plus 1 read edge.
- ld_ready is a registered function of state and is combinationally independent of ld_valid.
- ld_en rise: first word can be accepted the cycle after entry to LOAD.
- Loader throughput is 1 word/cycle.
- ld_count increments 1 cycle after an accepted word.
- cmd_err sets after the edge that samples the illegal command.

## Test plan
- Reset then MREAD addr 0x005 (preloaded 16'hA5A5) → read_data==16'hA5A5 after next edge; read_data==0 immediately after reset.
- MWRITE addr 0x010 data 16'h1234, then MREAD 0x010 → 16'h1234. MNONE for 3 cycles → read_data stays 16'h1234.
- MWRITE LED_ADDR data 16'hFF3C → led==8'h3C and RAM[0x100] unchanged. sw=8'h5A held 3 cycles, MREAD SW_ADDR → 16'h005A.
- mem_cmd=3'b110 → cmd_err==1, no RAM write. Further legal commands → cmd_err stays 1. Reset → 0.
- ld_en=1, stream 4 words with one ld_valid gap, ld_en=0 → RAM[0..3] match, ld_count==4. MREAD issued during LOAD is ignored.
- Load 512 words → FULL, ld_ready==0, 513th ld_valid ignored, ld_count==512. Reset mid-load after 10 words → IDLE, ld_count==0, RAM[0..9] retained.
